// File: rtl/tiny_risc_pkg.sv
// Shared definitions for the tiny RISC CPU: word widths and opcode encodings used by datapath and Controller.
// No logic; constants and types only.
package tiny_risc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;
  localparam int OP_W       = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LDA = 2'b00,
    OP_STA = 2'b01,
    OP_ADD = 2'b10,
    OP_JMP = 2'b11
  } opcode_t;

  // Opcode field of an instruction word, for the Controller's decoder.
  function automatic opcode_t decode_op(input logic [DATA_W_DEF-1:0] instr);
    return opcode_t'(instr[DATA_W_DEF-1 -: OP_W]);
  endfunction

endpackage

// File: rtl/tiny_risc_pc.sv
// Program counter: clr > ld > inc > hold, wrapping modulo 2**ADDR_W; new value visible one cycle after the strobe.
// Backpressure: none, strobes act every cycle they are high.
module tiny_risc_pc #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              ld,
  input  logic              inc,
  input  logic [ADDR_W-1:0] ld_val,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (ld) begin
      pc <= ld_val;
    end else if (inc) begin
      pc <= pc + PC_ONE;
    end
  end

endmodule

// File: rtl/tiny_risc_datapath.sv
// Tiny RISC datapath (PC, IR, AC, dbus, ALU); register loads visible next cycle, buses/ALU combinational, no backpressure.
// Optional carry flag register built only when TINY_RISC_CARRY_FLAG_EN is defined; otherwise carry is tied low.
module tiny_risc_datapath
  import tiny_risc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_on_adr,
  input  logic              pc_on_adr,
  input  logic              data_on_dbus,
  input  logic              alu_on_dbus,
  input  logic              dbus_on_data,
  input  logic              ld_ir,
  input  logic              ld_ac,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              clr_pc,
  input  logic              pass,
  input  logic              add,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  output logic [1:0]        op_code,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ac_out,
  output logic              bus_conflict,
  output logic              carry
);

  if (DATA_W - ADDR_W != OP_W) begin : g_bad_widths
    $error("tiny_risc_datapath: DATA_W-ADDR_W must equal 2");
  end

  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] ac_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] alu_sum;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] dbus;

`ifdef TINY_RISC_CARRY_FLAG_EN
  logic [DATA_W:0] sum_ext;
  logic            alu_cout;
  logic            carry_q;

  assign sum_ext  = {1'b0, ac_q} + {1'b0, mem_rdata};
  assign alu_sum  = sum_ext[DATA_W-1:0];
  assign alu_cout = sum_ext[DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else if (ld_ac && add) begin
      carry_q <= alu_cout;
    end
  end

  assign carry = carry_q;
`else
  assign alu_sum = ac_q + mem_rdata;
  assign carry   = 1'b0;
`endif

  // ALU operands are AC and mem_rdata, never dbus, so there is no combinational loop.
  always_comb begin
    alu_res = '0;
    if (add) begin
      alu_res = alu_sum;
    end else if (pass) begin
      alu_res = ac_q;
    end
  end

  always_comb begin
    dbus = '0;
    if (alu_on_dbus) begin
      dbus = alu_res;
    end else if (data_on_dbus) begin
      dbus = mem_rdata;
    end
  end

  always_comb begin
    adr = '0;
    if (ir_on_adr) begin
      adr = ir_q[ADDR_W-1:0];
    end else if (pc_on_adr) begin
      adr = pc_q;
    end
  end

  assign bus_conflict = (alu_on_dbus & data_on_dbus) | (ir_on_adr & pc_on_adr);

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q <= '0;
      ac_q <= '0;
    end else begin
      if (ld_ir) ir_q <= dbus;
      if (ld_ac) ac_q <= dbus;
    end
  end

  tiny_risc_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr_pc),
    .ld     (ld_pc),
    .inc    (inc_pc),
    .ld_val (ir_q[ADDR_W-1:0]),
    .pc     (pc_q)
  );

  assign mem_wdata    = dbus;
  assign mem_wdata_oe = dbus_on_data;
  assign op_code      = ir_q[DATA_W-1:ADDR_W];
  assign pc_out       = pc_q;
  assign ac_out       = ac_q;

endmodule

// File: doc/tiny_risc_datapath.md
Name: tiny_risc_datapath

Overview:
- Register-transfer datapath of the tiny RISC CPU, directly downstream of the Controller.
- Consumes the Controller's bus-select, register-load and ALU-function strobes.
- Holds PC, IR and AC, plus an internal data bus (dbus) and the ALU.
- Returns op_code (IR upper bits) to the Controller and drives the memory address and write-data lines.

Parameters:
DATA_W, 8, data/instruction word width
ADDR_W, 6, address width; opcode width is DATA_W-ADDR_W and must equal 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ir_on_adr  in  1  adr = IR[ADDR_W-1:0]
pc_on_adr  in  1  adr = PC
data_on_dbus  in  1  dbus = mem_rdata
alu_on_dbus  in  1  dbus = ALU result
dbus_on_data  in  1  drive mem_wdata from dbus
ld_ir  in  1  IR <= dbus
ld_ac  in  1  AC <= dbus
ld_pc  in  1  PC <= IR[ADDR_W-1:0]
inc_pc  in  1  PC <= PC+1
clr_pc  in  1  PC <= 0
pass  in  1  ALU result = AC
add  in  1  ALU result = AC + mem_rdata
mem_rdata  in  DATA_W  memory read data
adr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wdata_oe  out  1  write-data enable (= dbus_on_data)
op_code  out  2  IR[DATA_W-1:ADDR_W], to Controller
pc_out  out  ADDR_W  PC, for observation
ac_out  out  DATA_W  AC, for observation
bus_conflict  out  1  combinational: both dbus sources or both adr sources selected
carry  out  1  carry flag (see Optional Feature)

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: PC=0, IR=0, AC=0, carry=0. Consequently op_code=00, pc_out=0, ac_out=0.
- Reset mid-operation overrides every strobe in that cycle.
- ALU (combinational), operands AC and mem_rdata (never dbus, so no loop):
  - add=1: result = AC + mem_rdata, truncated to DATA_W; carry-out = bit DATA_W.
  - else pass=1: result = AC.
  - else: result = 0.
  - add and pass both high: add wins.
- dbus (combinational):
  - alu_on_dbus=1: ALU result.
  - else data_on_dbus=1: mem_rdata.
  - else: 0.
  - Both high: ALU wins; bus_conflict=1.
- adr (combinational):
  - ir_on_adr=1: IR[ADDR_W-1:0].
  - else pc_on_adr=1: PC.
  - else: 0.
  - Both high: IR wins; bus_conflict=1.
- mem_wdata = dbus at all times; mem_wdata_oe = dbus_on_data.
- PC update priority: clr_pc > ld_pc > inc_pc > hold.
  - inc_pc wraps 63 -> 0 (ADDR_W modular).
- IR and AC: load dbus at the edge when ld_ir / ld_ac is high; otherwise hold.
  - ld_ir and ld_ac in the same cycle: both load the same dbus value.
- Latency: all register loads are visible one cycle after the strobe. op_code follows IR with zero extra delay.

Optional Feature:
- Macro: TINY_RISC_CARRY_FLAG_EN.
- Defined: carry register loads the ALU carry-out when ld_ac=1 and add=1, holds otherwise, and is cleared by reset.
- Not defined: carry is tied to 0 and no flag register is built.

Decomposition:
- Package tiny_risc_pkg holds:
  - DATA_W/ADDR_W defaults.
  - Opcode constants: OP_LDA=2'b00, OP_STA=2'b01, OP_ADD=2'b10, OP_JMP=2'b11.
  - Shared with the Controller.
- Sub-module tiny_risc_pc: the PC register with clr/ld/inc priority and wrap-around.
- ALU, bus muxes, IR and AC stay inline.

Test Plan:
- Reset and fetch:
  - Stimulus: assert reset, then pc_on_adr, data_on_dbus, ld_ir, inc_pc with mem_rdata=8'h85.
  - Response: adr=0; next cycle IR=8'h85, op_code=2'b10, pc_out=1.
- LDA path:
  - Stimulus: ir_on_adr with IR=8'h05, then data_on_dbus+ld_ac with mem_rdata=8'h3C.
  - Response: adr=5; ac_out=8'h3C next cycle.
- ADD with wrap:
  - Stimulus: AC=8'hF0, mem_rdata=8'h20, add+alu_on_dbus+ld_ac.
  - Response: ac_out=8'h10; carry=1 with TINY_RISC_CARRY_FLAG_EN, carry=0 without.
- STA path:
  - Stimulus: AC=8'h5A, pass+alu_on_dbus+dbus_on_data.
  - Response: mem_wdata=8'h5A, mem_wdata_oe=1.
- PC control:
  - Stimulus: PC=63 with inc_pc.
  - Response: pc_out=0.
  - Stimulus: IR=8'hC7 with ld_pc+inc_pc.
  - Response: pc_out=7.
  - Stimulus: clr_pc+ld_pc.
  - Response: pc_out=0.
- Conflicts:
  - Stimulus: alu_on_dbus+data_on_dbus.
  - Response: dbus=ALU result, bus_conflict=1.
  - Stimulus: ir_on_adr+pc_on_adr.
  - Response: adr=IR[5:0], bus_conflict=1.
  - Stimulus: reset asserted together with ld_ac.
  - Response: ac_out=0.
